// File: rtl/flight_ctrl_sequencer_pkg.sv
// Shared encodings and limits for the flight control stage sequencer.
package flight_ctrl_sequencer_pkg;

  localparam int SEQ_MAX_STAGES      = 8;
  localparam int SEQ_DEFAULT_TIMEOUT = 255;
  localparam int SEQ_OVERRUN_W       = 8;
  localparam int SEQ_STAGE_IDX_W     = $clog2(SEQ_MAX_STAGES);
  localparam int SEQ_WDOG_W          = 16;

  // One-hot so each state decode is a single flop.
  typedef enum logic [4:0] {
    SEQ_STATE_IDLE   = 5'b00001,
    SEQ_STATE_SELECT = 5'b00010,
    SEQ_STATE_START  = 5'b00100,
    SEQ_STATE_WAIT   = 5'b01000,
    SEQ_STATE_DONE   = 5'b10000
  } seq_state_t;

  // Saturating increment for the dropped-request counter.
  function automatic logic [SEQ_OVERRUN_W-1:0] sat_inc(input logic [SEQ_OVERRUN_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/flight_ctrl_sequencer_if.sv
// Frame strobe / stage handshake / status bundle between host logic and the sequencer.
interface flight_ctrl_sequencer_if
  import flight_ctrl_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = 4
);

  logic                       update_req;
  logic [NUM_STAGES-1:0]      stage_enable;
  logic [NUM_STAGES-1:0]      stage_complete;
  logic                       err_clear;
  logic [NUM_STAGES-1:0]      stage_start;
  logic                       busy;
  logic                       frame_done;
  logic                       frame_aborted;
  logic                       timeout_err;
  logic [SEQ_STAGE_IDX_W-1:0] timeout_stage;
  logic [SEQ_OVERRUN_W-1:0]   overrun_count;

  modport master (
    output update_req, stage_enable, stage_complete, err_clear,
    input  stage_start, busy, frame_done, frame_aborted, timeout_err, timeout_stage, overrun_count
  );

  modport slave (
    input  update_req, stage_enable, stage_complete, err_clear,
    output stage_start, busy, frame_done, frame_aborted, timeout_err, timeout_stage, overrun_count
  );

endinterface

// File: rtl/flight_ctrl_sequencer_seq_watchdog.sv
// Per-stage watchdog: counts enabled cycles, flags the cycle in which the
// running count reaches the limit.
module flight_ctrl_sequencer_seq_watchdog
  import flight_ctrl_sequencer_pkg::*;
(
  input  logic                  us_clk,
  input  logic                  resetn,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [SEQ_WDOG_W-1:0] limit,
  output logic                  expired
);

  logic [SEQ_WDOG_W-1:0] count;
  logic [SEQ_WDOG_W:0]   count_next;

  // count_next is the value including this cycle, so a stage gets exactly
  // 'limit' WAIT cycles before expiry.
  assign count_next = {1'b0, count} + 1'b1;
  assign expired    = enable && (count_next >= {1'b0, limit});

  // Cycle counter, saturating so a huge limit never wraps back to zero.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/flight_ctrl_sequencer.sv
// Sequences controller stages in index order once per accepted frame, with
// per-stage watchdog abort, overrun accounting and sticky timeout status.
//
// state  | meaning
// IDLE   | waiting for update_req or a pending request
// SELECT | examine en_q[idx]; skip disabled stages one per cycle, end at idx==NUM_STAGES
// START  | stage_start[idx] is high this cycle; watchdog cleared
// WAIT   | waiting for stage_complete[idx] or watchdog expiry
// DONE   | frame_done (+frame_aborted) high this cycle; busy drops at next edge
module flight_ctrl_sequencer
  import flight_ctrl_sequencer_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = SEQ_DEFAULT_TIMEOUT
) (
  input logic                    us_clk,
  input logic                    resetn,
  flight_ctrl_sequencer_if.slave bus
);

  localparam int               IDX_W   = $clog2(NUM_STAGES + 1);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_STAGES);

  seq_state_t                 state;
  logic [IDX_W-1:0]           idx;
  logic [NUM_STAGES-1:0]      en_q;
  logic                       pending;
  logic                       abort_q;

  logic [NUM_STAGES-1:0]      stage_start_q;
  logic                       busy_q;
  logic                       frame_done_q;
  logic                       frame_aborted_q;
  logic                       timeout_err_q;
  logic [SEQ_STAGE_IDX_W-1:0] timeout_stage_q;
  logic [SEQ_OVERRUN_W-1:0]   overrun_q;

  logic [NUM_STAGES-1:0]      idx_hot;
  logic                       en_cur;
  logic                       cmp_cur;
  logic                       wd_clear;
  logic                       wd_enable;
  logic                       wd_expired;

  // Decoded idx; all zeros once idx runs past the last stage, so only the
  // complete bit of the stage being waited on can ever be seen.
  assign idx_hot   = NUM_STAGES'(1) << idx;
  assign en_cur    = |(en_q & idx_hot);
  assign cmp_cur   = |(bus.stage_complete & idx_hot);
  assign wd_clear  = (state == SEQ_STATE_START);
  assign wd_enable = (state == SEQ_STATE_WAIT);

  flight_ctrl_sequencer_seq_watchdog u_seq_watchdog (
    .us_clk  (us_clk),
    .resetn  (resetn),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .limit   (SEQ_WDOG_W'(TIMEOUT_CYCLES)),
    .expired (wd_expired)
  );

  // Frame FSM plus pending/overrun bookkeeping and sticky timeout status.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state           <= SEQ_STATE_IDLE;
      idx             <= '0;
      en_q            <= '0;
      pending         <= 1'b0;
      abort_q         <= 1'b0;
      stage_start_q   <= '0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_aborted_q <= 1'b0;
      timeout_err_q   <= 1'b0;
      timeout_stage_q <= '0;
      overrun_q       <= '0;
    end else begin
      stage_start_q   <= '0;
      frame_done_q    <= 1'b0;
      frame_aborted_q <= 1'b0;

      if (bus.err_clear) begin
        timeout_err_q   <= 1'b0;
        timeout_stage_q <= '0;
      end

      // One request can be queued behind the running frame; further ones are dropped and counted.
      if (bus.update_req && busy_q) begin
        if (!pending) begin
          pending <= 1'b1;
        end else begin
          overrun_q <= sat_inc(overrun_q);
        end
      end

      case (state)
        SEQ_STATE_IDLE: begin
          if (bus.update_req || pending) begin
            en_q    <= bus.stage_enable;
            idx     <= '0;
            pending <= 1'b0;
            busy_q  <= 1'b1;
            state   <= SEQ_STATE_SELECT;
          end
        end
        SEQ_STATE_SELECT: begin
          if (idx >= IDX_END) begin
            frame_done_q    <= 1'b1;
            frame_aborted_q <= abort_q;
            state           <= SEQ_STATE_DONE;
          end else if (!en_cur) begin
            idx <= idx + 1'b1;
          end else begin
            stage_start_q <= idx_hot;
            state         <= SEQ_STATE_START;
          end
        end
        SEQ_STATE_START: begin
          state <= SEQ_STATE_WAIT;
        end
        SEQ_STATE_WAIT: begin
          // A completion on the expiry cycle still counts as success.
          if (cmp_cur) begin
            idx   <= idx + 1'b1;
            state <= SEQ_STATE_SELECT;
          end else if (wd_expired) begin
            timeout_err_q   <= 1'b1;
            timeout_stage_q <= SEQ_STAGE_IDX_W'(idx);
            abort_q         <= 1'b1;
            frame_done_q    <= 1'b1;
            frame_aborted_q <= 1'b1;
            state           <= SEQ_STATE_DONE;
          end
        end
        SEQ_STATE_DONE: begin
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
          state   <= SEQ_STATE_IDLE;
        end
        default: begin
          state <= SEQ_STATE_IDLE;
        end
      endcase
    end
  end

  assign bus.stage_start   = stage_start_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.frame_aborted = frame_aborted_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.timeout_stage = timeout_stage_q;
  assign bus.overrun_count = overrun_q;

endmodule

// File: tb/tb_flight_ctrl_sequencer.sv
// Testbench for flight_ctrl_sequencer: vector table, directed corner cases,
// and random frames checked against a frame-timing reference model.
module tb_flight_ctrl_sequencer;

  localparam int NS  = 4;
  localparam int TMO = 255;
  localparam int NV  = 7;

  logic us_clk = 1'b0;
  logic resetn = 1'b0;

  always #5 us_clk = ~us_clk;

  flight_ctrl_sequencer_if #(.NUM_STAGES(NS)) bus ();

  flight_ctrl_sequencer #(.NUM_STAGES(NS), .TIMEOUT_CYCLES(TMO)) dut (
    .us_clk (us_clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    int c;
    int i;
  } start_ev_t;

  typedef struct {
    string         name;
    logic [NS-1:0] mask;
    int            d0, d1, d2, d3;
    logic [NS-1:0] noise;
    logic [NS-1:0] exp_started;
    bit            exp_abort;
    int            exp_ts;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int            delay_cfg [NS];   // 0 = stage never completes
  int            due [NS];
  logic [NS-1:0] noise_mask;
  bit            clr_arm;
  int            clr_at;
  start_ev_t     got_q [$];
  start_ev_t     exp_q [$];
  int            done_cnt = 0;
  int            last_done_cyc;
  logic          last_aborted;
  logic          last_done_busy;
  int            multi_hot;
  int            orphan_abort;
  bit            exp_err;
  int            exp_tstage;
  vec_t          vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs just after the edge, then drive this cycle's stage responses.
  task automatic tick();
    logic [NS-1:0] comp;
    @(posedge us_clk);
    #1;
    cyc++;
    if ($countones(bus.stage_start) > 1) multi_hot++;
    for (int i = 0; i < NS; i++) begin
      if (bus.stage_start[i] === 1'b1) begin
        got_q.push_back('{cyc, i});
        due[i] = (delay_cfg[i] == 0) ? -1 : cyc + delay_cfg[i];
        if (clr_arm) clr_at = cyc + TMO;
      end
    end
    if (bus.frame_done === 1'b1) begin
      done_cnt++;
      last_done_cyc  = cyc;
      last_aborted   = bus.frame_aborted;
      last_done_busy = bus.busy;
    end else if (bus.frame_aborted === 1'b1) begin
      orphan_abort++;
    end
    comp = '0;
    for (int i = 0; i < NS; i++) if (due[i] == cyc) comp[i] = 1'b1;
    if (cyc % 3 == 0) comp = comp | noise_mask;
    bus.stage_complete = comp;
    bus.err_clear      = (cyc == clr_at);
  endtask

  // Frame timing from the rules: request in cycle r -> first stage examined in r+1;
  // a skipped stage costs one cycle; an enabled stage starts one cycle after it is
  // examined; its completion in cycle c moves examination to c+1; a stage that has
  // not completed by its TMO-th waiting cycle ends the frame one cycle later.
  task automatic model(input int req_cyc, input logic [NS-1:0] mask,
                       output int done_c, output bit ab, output int ts);
    int c;
    int s;
    exp_q.delete();
    ab = 1'b0;
    ts = 0;
    c  = req_cyc + 1;
    for (int i = 0; i < NS; i++) begin
      if (!mask[i]) begin
        c++;
        continue;
      end
      s = c + 1;
      exp_q.push_back('{s, i});
      if (delay_cfg[i] == 0 || delay_cfg[i] > TMO) begin
        ab     = 1'b1;
        ts     = i;
        done_c = s + TMO + 1;
        return;
      end
      c = s + delay_cfg[i] + 1;
    end
    done_c = c + 1;
  endtask

  task automatic run_frame(input logic [NS-1:0] mask, input string tag);
    int req_c;
    int exp_done;
    bit exp_ab;
    int exp_ts;
    int d0;
    int budget;
    int n;
    got_q.delete();
    multi_hot    = 0;
    orphan_abort = 0;
    d0           = done_cnt;
    bus.stage_enable = mask;
    bus.update_req   = 1'b1;
    req_c = cyc;
    model(req_c, mask, exp_done, exp_ab, exp_ts);
    tick();
    bus.update_req = 1'b0;
    budget = 0;
    while (done_cnt == d0 && budget < 3000) begin
      tick();
      budget++;
    end
    check({tag, " frame_done_count"}, done_cnt - d0, 1);
    check({tag, " start_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check({tag, " start_idx"}, got_q[k].i, exp_q[k].i);
      check({tag, " start_cycle"}, got_q[k].c, exp_q[k].c);
    end
    check({tag, " done_cycle"}, last_done_cyc, exp_done);
    check({tag, " frame_aborted"}, int'(last_aborted), int'(exp_ab));
    check({tag, " busy_on_done"}, int'(last_done_busy), 1);
    if (exp_ab) begin
      exp_err    = 1'b1;
      exp_tstage = exp_ts;
    end
    tick();
    check({tag, " busy_after"}, int'(bus.busy), 0);
    check({tag, " timeout_err"}, int'(bus.timeout_err), int'(exp_err));
    check({tag, " timeout_stage"}, int'(bus.timeout_stage), exp_tstage);
    check({tag, " multi_hot_start"}, multi_hot, 0);
    check({tag, " abort_without_done"}, orphan_abort, 0);
    for (int i = 0; i < NS; i++) due[i] = -1;
    noise_mask = '0;
    bus.stage_complete = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stage_start"}, int'(bus.stage_start), 0);
    check({tag, " busy"}, int'(bus.busy), 0);
    check({tag, " frame_done"}, int'(bus.frame_done), 0);
    check({tag, " frame_aborted"}, int'(bus.frame_aborted), 0);
    check({tag, " timeout_err"}, int'(bus.timeout_err), 0);
    check({tag, " timeout_stage"}, int'(bus.timeout_stage), 0);
    check({tag, " overrun_count"}, int'(bus.overrun_count), 0);
  endtask

  task automatic set_delays(input int a, input int b, input int c, input int d);
    delay_cfg[0] = a;
    delay_cfg[1] = b;
    delay_cfg[2] = c;
    delay_cfg[3] = d;
  endtask

  initial begin
    logic [NS-1:0] sm;
    logic [NS-1:0] rm;
    int d0;
    int budget;

    vecs[0] = '{"all4",       4'b1111,   6,   6, 6, 6, 4'b0000, 4'b1111, 1'b0, 0};
    vecs[1] = '{"mask0101",   4'b0101,   6,   6, 6, 6, 4'b1010, 4'b0101, 1'b0, 0};
    vecs[2] = '{"stage1_hang",4'b1111,   6,   0, 6, 6, 4'b0000, 4'b0011, 1'b1, 1};
    vecs[3] = '{"none",       4'b0000,   6,   6, 6, 6, 4'b1111, 4'b0000, 1'b0, 0};
    vecs[4] = '{"expiry_ok",  4'b1111,   3, 255, 2, 1, 4'b0000, 4'b1111, 1'b0, 0};
    vecs[5] = '{"last_only",  4'b1000,   1,   1, 1, 1, 4'b0111, 4'b1000, 1'b0, 0};
    vecs[6] = '{"one_late",   4'b0011, 256,   4, 4, 4, 4'b1100, 4'b0001, 1'b1, 0};

    bus.update_req     = 1'b0;
    bus.stage_enable   = '0;
    bus.stage_complete = '0;
    bus.err_clear      = 1'b0;
    for (int i = 0; i < NS; i++) begin
      delay_cfg[i] = 6;
      due[i]       = -1;
    end
    noise_mask = '0;
    clr_arm    = 1'b0;
    clr_at     = -1;
    exp_err    = 1'b0;
    exp_tstage = 0;

    resetn = 1'b0;
    repeat (3) tick();
    check_all_zero("rst_hold");
    resetn = 1'b1;
    tick();
    tick();
    check_all_zero("rst_release");

    for (int v = 0; v < NV; v++) begin
      set_delays(vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].d3);
      noise_mask = vecs[v].noise;
      run_frame(vecs[v].mask, vecs[v].name);
      sm = '0;
      foreach (got_q[k]) sm[got_q[k].i] = 1'b1;
      check({vecs[v].name, " started_mask"}, int'(sm), int'(vecs[v].exp_started));
      check({vecs[v].name, " aborted"}, int'(last_aborted), int'(vecs[v].exp_abort));
      if (vecs[v].exp_abort)
        check({vecs[v].name, " tstage"}, int'(bus.timeout_stage), vecs[v].exp_ts);
    end

    clr_at = cyc + 1;
    tick();
    tick();
    exp_err    = 1'b0;
    exp_tstage = 0;
    check("err_clear timeout_err", int'(bus.timeout_err), 0);
    check("err_clear timeout_stage", int'(bus.timeout_stage), 0);

    set_delays(5, 0, 5, 5);
    clr_arm = 1'b1;
    run_frame(4'b0010, "clear_vs_timeout");
    clr_arm = 1'b0;
    clr_at  = -1;
    check("clear_vs_timeout err_kept", int'(bus.timeout_err), 1);
    check("clear_vs_timeout stage", int'(bus.timeout_stage), 1);

    set_delays(6, 6, 6, 6);
    d0 = done_cnt;
    bus.stage_enable = 4'b1111;
    bus.update_req   = 1'b1;
    tick();
    bus.update_req = 1'b0;
    repeat (3) begin
      tick();
      tick();
      bus.update_req = 1'b1;
      tick();
      bus.update_req = 1'b0;
    end
    budget = 0;
    while (done_cnt - d0 < 2 && budget < 2000) begin
      tick();
      budget++;
    end
    repeat (40) tick();
    check("overrun frames_run", done_cnt - d0, 2);
    check("overrun count_2", int'(bus.overrun_count), 2);

    set_delays(200, 200, 200, 200);
    d0 = done_cnt;
    bus.update_req = 1'b1;
    tick();
    bus.update_req = 1'b0;
    repeat (3) tick();
    bus.update_req = 1'b1;
    repeat (300) tick();
    bus.update_req = 1'b0;
    check("overrun saturate", int'(bus.overrun_count), 255);
    budget = 0;
    while (done_cnt - d0 < 2 && budget < 3000) begin
      tick();
      budget++;
    end
    repeat (10) tick();
    check("overrun sat frames_run", done_cnt - d0, 2);
    clr_at = cyc + 1;
    tick();
    tick();
    check("err_clear keeps overrun", int'(bus.overrun_count), 255);
    for (int i = 0; i < NS; i++) due[i] = -1;
    bus.stage_complete = '0;

    for (int r = 0; r < 25; r++) begin
      rm = NS'($urandom_range(0, 15));
      for (int i = 0; i < NS; i++) begin
        case ($urandom_range(0, 9))
          0:       delay_cfg[i] = 0;
          1:       delay_cfg[i] = $urandom_range(TMO - 1, TMO + 1);
          default: delay_cfg[i] = $urandom_range(1, 10);
        endcase
      end
      noise_mask = ~rm;
      run_frame(rm, "rand");
    end

    set_delays(6, 6, 60, 6);
    got_q.delete();
    bus.stage_enable = 4'b1111;
    bus.update_req   = 1'b1;
    tick();
    bus.update_req = 1'b0;
    budget = 0;
    while (got_q.size() < 3 && budget < 300) begin
      tick();
      budget++;
    end
    check("midrst reached_stage2", got_q.size(), 3);
    repeat (4) tick();
    check("midrst busy_before", int'(bus.busy), 1);
    resetn = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int i = 0; i < NS; i++) due[i] = -1;
    bus.stage_complete = '0;
    tick();
    tick();
    check_all_zero("midrst_hold");
    resetn     = 1'b1;
    exp_err    = 1'b0;
    exp_tstage = 0;
    tick();
    set_delays(4, 4, 4, 4);
    run_frame(4'b1111, "post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
